panda_risc_v_icb_mem_arb: RTL and testbench

- 2-to-1 ICB arbiter sharing one unified memory port between the instruction-fetch bus and the data-access bus of panda_risc_v_sim.
- Used when IMEM and DMEM are one image, e.g. ISA tests with a shared .mem file.
- Commands are arbitrated and forwarded with zero added latency.
- An in-order grant-ID FIFO routes each slave response back to the master that issued the command.

---
 rtl/panda_risc_v_icb_pkg.sv | 9 +
 rtl/panda_risc_v_icb_mem_arb_if.sv | 22 ++
 rtl/panda_risc_v_icb_id_fifo.sv | 45 ++++
 rtl/panda_risc_v_icb_mem_arb.sv | 82 ++++++++
 tb/tb_panda_risc_v_icb_mem_arb.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/panda_risc_v_icb_pkg.sv
// panda_risc_v_icb_pkg: shared types and constants for the ICB memory arbiter
package panda_risc_v_icb_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;
  localparam string ARB_ROUND_ROBIN = "round_robin";
  localparam string ARB_DATA_FIRST = "data_first";
  typedef enum logic {GNT_INST = 1'b0, GNT_DATA = 1'b1} grant_id_t;
endpackage

// File: rtl/panda_risc_v_icb_mem_arb_if.sv
// panda_risc_v_icb_mem_arb_if: one ICB link (command + response channels)
interface panda_risc_v_icb_mem_arb_if;
  import panda_risc_v_icb_pkg::*;
  logic [ADDR_W-1:0] cmd_addr;
  logic cmd_read;
  logic [DATA_W-1:0] cmd_wdata;
  logic [MASK_W-1:0] cmd_wmask;
  logic cmd_valid;
  logic cmd_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic rsp_err;
  logic rsp_valid;
  logic rsp_ready;
  modport master (
    output cmd_addr, cmd_read, cmd_wdata, cmd_wmask, cmd_valid, rsp_ready,
    input cmd_ready, rsp_rdata, rsp_err, rsp_valid
  );
  modport slave (
    input cmd_addr, cmd_read, cmd_wdata, cmd_wmask, cmd_valid, rsp_ready,
    output cmd_ready, rsp_rdata, rsp_err, rsp_valid
  );
endinterface

// File: rtl/panda_risc_v_icb_id_fifo.sv
// panda_risc_v_icb_id_fifo: in-order FIFO of grant IDs for commands in flight
module panda_risc_v_icb_id_fifo
  import panda_risc_v_icb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  grant_id_t din,
  input  logic pop,
  output grant_id_t dout,
  output logic full,
  output logic empty,
  output logic [3:0] count
);
  localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  grant_id_t mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic do_push;
  logic do_pop;
  assign full = count == 4'(DEPTH);
  assign empty = count == 4'd0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem[rd_ptr];
  // ID storage; contents are only meaningful between push and pop
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  // pointers wrap at DEPTH; simultaneous push and pop keep the count steady
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
      count <= count + 4'(do_push) - 4'(do_pop);
    end
  end
endmodule

// File: rtl/panda_risc_v_icb_mem_arb.sv
// panda_risc_v_icb_mem_arb: 2-to-1 ICB arbiter sharing one memory port between fetch and data
module panda_risc_v_icb_mem_arb
  import panda_risc_v_icb_pkg::*;
#(
  parameter int OUTSTANDING_N = 4,
  parameter string ARB_MODE = "round_robin",
  parameter int SIM_DELAY = 1
) (
  input  logic clk,
  input  logic rst,
  panda_risc_v_icb_mem_arb_if.slave s_inst,
  panda_risc_v_icb_mem_arb_if.slave s_data,
  panda_risc_v_icb_mem_arb_if.master m,
  output logic [3:0] outstanding_cnt,
  output logic orphan_rsp
);
  localparam bit DATA_FIRST = ARB_MODE == ARB_DATA_FIRST;
  if ((OUTSTANDING_N != 1 && OUTSTANDING_N != 2 && OUTSTANDING_N != 4 && OUTSTANDING_N != 8) ||
      SIM_DELAY < 0 || (ARB_MODE != ARB_ROUND_ROBIN && !DATA_FIRST)) begin : g_bad_param
    $error("panda_risc_v_icb_mem_arb: unsupported parameter value");
  end
  grant_id_t gnt;
  grant_id_t lock_id;
  grant_id_t last_grant;
  grant_id_t head;
  logic lock;
  logic inst_v;
  logic data_v;
  logic gnt_v;
  logic full;
  logic empty;
  logic fire;
  logic pop;
  assign inst_v = s_inst.cmd_valid;
  assign data_v = s_data.cmd_valid;
  // a stalled command keeps its grant; otherwise contention goes by mode, else to whoever asks
  assign gnt = lock ? lock_id
             : (inst_v && data_v) ? (DATA_FIRST ? GNT_DATA : grant_id_t'(~last_grant))
             : data_v ? GNT_DATA : GNT_INST;
  assign gnt_v = gnt == GNT_DATA ? data_v : inst_v;
  assign m.cmd_valid = gnt_v & ~full;
  assign fire = m.cmd_valid & m.cmd_ready;
  assign m.cmd_addr = gnt == GNT_DATA ? s_data.cmd_addr : s_inst.cmd_addr;
  assign m.cmd_read = gnt == GNT_DATA ? s_data.cmd_read : s_inst.cmd_read;
  assign m.cmd_wdata = gnt == GNT_DATA ? s_data.cmd_wdata : s_inst.cmd_wdata;
  assign m.cmd_wmask = gnt == GNT_DATA ? s_data.cmd_wmask : s_inst.cmd_wmask;
  assign s_inst.cmd_ready = (gnt == GNT_INST) & m.cmd_ready & ~full;
  assign s_data.cmd_ready = (gnt == GNT_DATA) & m.cmd_ready & ~full;
  assign s_inst.rsp_valid = m.rsp_valid & ~empty & (head == GNT_INST);
  assign s_data.rsp_valid = m.rsp_valid & ~empty & (head == GNT_DATA);
  assign s_inst.rsp_rdata = m.rsp_rdata;
  assign s_data.rsp_rdata = m.rsp_rdata;
  assign s_inst.rsp_err = m.rsp_err;
  assign s_data.rsp_err = m.rsp_err;
  assign m.rsp_ready = empty | (head == GNT_DATA ? s_data.rsp_ready : s_inst.rsp_ready);
  assign pop = m.rsp_valid & m.rsp_ready;
  panda_risc_v_icb_id_fifo #(.DEPTH(OUTSTANDING_N)) u_id_fifo (
    .clk(clk),
    .rst(rst),
    .push(fire),
    .din(gnt),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(outstanding_cnt)
  );
  // grant lock, round-robin history and orphan-response pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      lock <= 1'b0;
      lock_id <= GNT_INST;
      last_grant <= GNT_DATA;
      orphan_rsp <= 1'b0;
    end else begin
      lock <= gnt_v & ~fire;
      lock_id <= gnt;
      if (fire) last_grant <= gnt;
      orphan_rsp <= m.rsp_valid & empty;
    end
  end
endmodule

// File: tb/tb_panda_risc_v_icb_mem_arb.sv
// tb_panda_risc_v_icb_mem_arb: scoreboard bench for the ICB memory arbiter
module tb_panda_risc_v_icb_mem_arb;
  import panda_risc_v_icb_pkg::*;
  typedef struct packed {
    logic [31:0] addr;
    logic read;
    logic [31:0] wdata;
    logic [3:0] wmask;
  } cmd_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] cnt;
  logic [3:0] df_cnt;
  logic orphan;
  logic df_orphan;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int first_rsp_cyc = -1;
  int inst_rsp_n = 0;
  logic data_rsp_seen = 1'b0;
  logic [31:0] last_inst_rdata = '0;
  logic mem_ready = 1'b1;
  logic rsp_en = 1'b1;
  logic inj = 1'b0;
  logic [31:0] mem [4096];
  logic [31:0] ref_mem [4096];
  logic [31:0] pend [$];
  cmd_t mem_log [$];
  cmd_t inst_q [$];
  cmd_t data_q [$];
  logic [31:0] exp_inst [$];
  logic [31:0] exp_data [$];
  grant_id_t fired [$];
  int fire_cyc [$];
  panda_risc_v_icb_mem_arb_if inst_if ();
  panda_risc_v_icb_mem_arb_if data_if ();
  panda_risc_v_icb_mem_arb_if mem_if ();
  panda_risc_v_icb_mem_arb_if df_inst ();
  panda_risc_v_icb_mem_arb_if df_data ();
  panda_risc_v_icb_mem_arb_if df_mem ();
  panda_risc_v_icb_mem_arb #(.OUTSTANDING_N(4), .ARB_MODE("round_robin"), .SIM_DELAY(1)) dut (
    .clk(clk), .rst(rst), .s_inst(inst_if), .s_data(data_if), .m(mem_if),
    .outstanding_cnt(cnt), .orphan_rsp(orphan)
  );
  panda_risc_v_icb_mem_arb #(.OUTSTANDING_N(4), .ARB_MODE("data_first"), .SIM_DELAY(1)) dut_df (
    .clk(clk), .rst(rst), .s_inst(df_inst), .s_data(df_data), .m(df_mem),
    .outstanding_cnt(df_cnt), .orphan_rsp(df_orphan)
  );
  always #5 clk = ~clk;
  assign mem_if.cmd_ready = mem_ready;
  initial begin
    #200000;
    $display("FAIL watchdog expired cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        pend.delete();
        mem_if.rsp_valid <= 1'b0;
        mem_if.rsp_rdata <= '0;
        mem_if.rsp_err <= 1'b0;
      end else begin
        if (mem_if.rsp_valid && mem_if.rsp_ready && pend.size() > 0) void'(pend.pop_front());
        if (mem_if.cmd_valid && mem_if.cmd_ready) begin
          mem_log.push_back({mem_if.cmd_addr, mem_if.cmd_read, mem_if.cmd_wdata, mem_if.cmd_wmask});
          if (mem_if.cmd_read) pend.push_back(mem[mem_if.cmd_addr[13:2]]);
          else begin
            for (int b = 0; b < 4; b++)
              if (mem_if.cmd_wmask[b]) mem[mem_if.cmd_addr[13:2]][8*b +: 8] = mem_if.cmd_wdata[8*b +: 8];
            pend.push_back(32'h0);
          end
        end
        mem_if.rsp_valid <= inj || (rsp_en && pend.size() > 0);
        mem_if.rsp_rdata <= pend.size() > 0 ? pend[0] : 32'hDEAD_BEEF;
        mem_if.rsp_err <= 1'b0;
      end
    end
  end
  function automatic logic [31:0] issue(cmd_t c);
    if (c.read) return ref_mem[c.addr[13:2]];
    for (int b = 0; b < 4; b++)
      if (c.wmask[b]) ref_mem[c.addr[13:2]][8*b +: 8] = c.wdata[8*b +: 8];
    return 32'h0;
  endfunction
  function automatic cmd_t rd(logic [31:0] a);
    return {a, 1'b1, 32'h0, 4'h0};
  endfunction
  task automatic tick();
    cmd_t ic;
    cmd_t dc;
    logic [31:0] e;
    ic = inst_q.size() > 0 ? inst_q[0] : '0;
    dc = data_q.size() > 0 ? data_q[0] : '0;
    inst_if.cmd_valid = inst_q.size() > 0;
    data_if.cmd_valid = data_q.size() > 0;
    {inst_if.cmd_addr, inst_if.cmd_read, inst_if.cmd_wdata, inst_if.cmd_wmask} = ic;
    {data_if.cmd_addr, data_if.cmd_read, data_if.cmd_wdata, data_if.cmd_wmask} = dc;
    #1;
    if (inst_if.cmd_valid && inst_if.cmd_ready && data_if.cmd_valid && data_if.cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL double_grant cycle=%0d got=both required=one", cyc);
    end
    if (inst_if.cmd_valid && inst_if.cmd_ready) begin
      exp_inst.push_back(issue(inst_q.pop_front()));
      fired.push_back(GNT_INST);
      fire_cyc.push_back(cyc);
    end
    if (data_if.cmd_valid && data_if.cmd_ready) begin
      exp_data.push_back(issue(data_q.pop_front()));
      fired.push_back(GNT_DATA);
      fire_cyc.push_back(cyc);
    end
    if (data_if.rsp_valid) data_rsp_seen = 1'b1;
    if (inst_if.rsp_valid && inst_if.rsp_ready) begin
      checks++;
      if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
      inst_rsp_n++;
      last_inst_rdata = inst_if.rsp_rdata;
      if (exp_inst.size() == 0) begin
        failures++;
        $display("FAIL inst_rsp_unexpected got=%h required=none", inst_if.rsp_rdata);
      end else begin
        e = exp_inst.pop_front();
        if (inst_if.rsp_rdata !== e) begin
          failures++;
          $display("FAIL inst_rsp_rdata got=%h required=%h", inst_if.rsp_rdata, e);
        end
      end
    end
    if (data_if.rsp_valid && data_if.rsp_ready) begin
      checks++;
      if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
      if (exp_data.size() == 0) begin
        failures++;
        $display("FAIL data_rsp_unexpected got=%h required=none", data_if.rsp_rdata);
      end else begin
        e = exp_data.pop_front();
        if (data_if.rsp_rdata !== e) begin
          failures++;
          $display("FAIL data_rsp_rdata got=%h required=%h", data_if.rsp_rdata, e);
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask
  task automatic run_fires(input int k, input string name);
    int n = 0;
    while (fire_cyc.size() < k && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (fire_cyc.size() < k) begin
      failures++;
      $display("FAIL %s_fire_timeout got=%0d required=%0d", name, fire_cyc.size(), k);
    end
  endtask
  task automatic drain(input string name);
    int n = 0;
    while ((inst_q.size() + data_q.size() + exp_inst.size() + exp_data.size()) > 0 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL %s_drain_timeout got=%0d required=0", name, exp_inst.size() + exp_data.size());
    end
  endtask
  task automatic apply_reset();
    rst = 1'b1;
    inst_q.delete();
    data_q.delete();
    exp_inst.delete();
    exp_data.delete();
    fired.delete();
    fire_cyc.delete();
    mem_log.delete();
    first_rsp_cyc = -1;
    inst_rsp_n = 0;
    data_rsp_seen = 1'b0;
    inst_if.cmd_valid = 1'b0;
    data_if.cmd_valid = 1'b0;
    inst_if.rsp_ready = 1'b1;
    data_if.rsp_ready = 1'b1;
    df_inst.cmd_valid = 1'b0;
    df_data.cmd_valid = 1'b0;
    df_mem.cmd_ready = 1'b0;
    mem_ready = 1'b1;
    rsp_en = 1'b1;
    inj = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (cnt !== 4'd0 || orphan !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got=cnt %0d orphan %b required=cnt 0 orphan 0", cnt, orphan);
    end
    checks++;
    if (inst_if.rsp_valid !== 1'b0 || data_if.rsp_valid !== 1'b0 || mem_if.rsp_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_rsp got=%b%b%b required=001", inst_if.rsp_valid, data_if.rsp_valid, mem_if.rsp_ready);
    end
    apply_reset();
  endtask
  task automatic test_fetch_only();
    apply_reset();
    inst_q.push_back(rd(32'h0));
    inst_q.push_back(rd(32'h4));
    inst_q.push_back(rd(32'h8));
    run_fires(3, "fetch_only");
    checks++;
    if (fire_cyc.size() != 3 || fire_cyc[2] - fire_cyc[0] != 2 || fired[0] != GNT_INST || fired[2] != GNT_INST) begin
      failures++;
      $display("FAIL fetch_only_consecutive got=%0d fires span %0d required=3 fires span 2",
               fire_cyc.size(), fire_cyc.size() == 3 ? fire_cyc[2] - fire_cyc[0] : -1);
    end
    drain("fetch_only");
    checks++;
    if (inst_rsp_n != 3 || data_rsp_seen !== 1'b0) begin
      failures++;
      $display("FAIL fetch_only_routing got=inst %0d data_seen %b required=inst 3 data_seen 0", inst_rsp_n, data_rsp_seen);
    end
  endtask
  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      inst_q.push_back(rd(32'h10 + 32'(4 * i)));
      data_q.push_back(rd(32'h20 + 32'(4 * i)));
    end
    run_fires(6, "round_robin");
    for (int i = 0; i < 6 && i < fired.size(); i++) begin
      checks++;
      if (fired[i] != ((i % 2 == 0) ? GNT_INST : GNT_DATA)) begin
        failures++;
        $display("FAIL rr_grant_%0d got=%0d required=%0d", i, fired[i], i % 2);
      end
    end
    checks++;
    if (fire_cyc.size() != 6 || fire_cyc[5] - fire_cyc[0] != 5) begin
      failures++;
      $display("FAIL rr_back_to_back got=%0d fires required=6 on consecutive cycles", fire_cyc.size());
    end
    drain("round_robin");
  endtask
  task automatic test_lock();
    apply_reset();
    df_inst.cmd_addr = 32'h100;
    df_inst.cmd_read = 1'b1;
    df_inst.cmd_wdata = '0;
    df_inst.cmd_wmask = '0;
    df_data.cmd_addr = 32'h200;
    df_data.cmd_read = 1'b1;
    df_data.cmd_wdata = '0;
    df_data.cmd_wmask = '0;
    df_inst.cmd_valid = 1'b1;
    df_mem.cmd_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) df_data.cmd_valid = 1'b1;
      #1;
      checks++;
      if (df_mem.cmd_addr !== 32'h100 || df_mem.cmd_valid !== 1'b1 || df_data.cmd_ready !== 1'b0) begin
        failures++;
        $display("FAIL lock_hold_%0d got=addr %h valid %b data_ready %b required=addr 100 valid 1 data_ready 0",
                 c, df_mem.cmd_addr, df_mem.cmd_valid, df_data.cmd_ready);
      end
      @(negedge clk);
    end
    df_mem.cmd_ready = 1'b1;
    #1;
    checks++;
    if (df_inst.cmd_ready !== 1'b1 || df_mem.cmd_addr !== 32'h100) begin
      failures++;
      $display("FAIL lock_release got=inst_ready %b addr %h required=1 100", df_inst.cmd_ready, df_mem.cmd_addr);
    end
    @(negedge clk);
    df_inst.cmd_valid = 1'b0;
    #1;
    checks++;
    if (df_data.cmd_ready !== 1'b1 || df_mem.cmd_addr !== 32'h200) begin
      failures++;
      $display("FAIL lock_next_data got=data_ready %b addr %h required=1 200", df_data.cmd_ready, df_mem.cmd_addr);
    end
    @(negedge clk);
    df_data.cmd_valid = 1'b0;
    #1;
    checks++;
    if (df_cnt !== 4'd2) begin
      failures++;
      $display("FAIL lock_count got=%0d required=2", df_cnt);
    end
    @(negedge clk);
    df_inst.cmd_addr = 32'h300;
    df_data.cmd_addr = 32'h400;
    df_inst.cmd_valid = 1'b1;
    df_data.cmd_valid = 1'b1;
    #1;
    checks++;
    if (df_data.cmd_ready !== 1'b1 || df_inst.cmd_ready !== 1'b0 || df_mem.cmd_addr !== 32'h400) begin
      failures++;
      $display("FAIL data_first_contention got=data_ready %b inst_ready %b addr %h required=1 0 400",
               df_data.cmd_ready, df_inst.cmd_ready, df_mem.cmd_addr);
    end
    @(negedge clk);
    df_inst.cmd_valid = 1'b0;
    df_data.cmd_valid = 1'b0;
  endtask
  task automatic test_full();
    apply_reset();
    rsp_en = 1'b0;
    for (int i = 0; i < 5; i++) inst_q.push_back(rd(32'h40 + 32'(4 * i)));
    run_fires(4, "full_fill");
    checks++;
    if (cnt !== 4'd4 || mem_if.cmd_valid !== 1'b0 || inst_if.cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_block got=cnt %0d valid %b ready %b required=cnt 4 valid 0 ready 0",
               cnt, mem_if.cmd_valid, inst_if.cmd_ready);
    end
    rsp_en = 1'b1;
    run_fires(5, "full_resume");
    checks++;
    if (fire_cyc.size() != 5 || fire_cyc[4] != first_rsp_cyc + 1) begin
      failures++;
      $display("FAIL full_resume_cycle got=%0d required=%0d",
               fire_cyc.size() == 5 ? fire_cyc[4] : -1, first_rsp_cyc + 1);
    end
    drain("full");
  endtask
  task automatic test_store_load();
    apply_reset();
    data_q.push_back({32'h3000, 1'b0, 32'h3000_0001, 4'hF});
    run_fires(1, "store");
    inst_q.push_back(rd(32'h3000));
    drain("store_load");
    checks++;
    if (last_inst_rdata !== 32'h3000_0001) begin
      failures++;
      $display("FAIL store_load_rdata got=%h required=30000001", last_inst_rdata);
    end
    checks++;
    if (mem_log.size() != 2 || mem_log[0].read !== 1'b0 || mem_log[0].addr !== 32'h3000 ||
        mem_log[1].read !== 1'b1 || mem_log[1].addr !== 32'h3000) begin
      failures++;
      $display("FAIL store_load_order got=%0d ops required=write then read at 3000", mem_log.size());
    end
  endtask
  task automatic test_orphan_reset();
    apply_reset();
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    #1;
    checks++;
    if (mem_if.rsp_valid !== 1'b1 || mem_if.rsp_ready !== 1'b1 || inst_if.rsp_valid !== 1'b0 ||
        data_if.rsp_valid !== 1'b0 || orphan !== 1'b0) begin
      failures++;
      $display("FAIL orphan_accept got=%b%b%b%b%b required=11000", mem_if.rsp_valid, mem_if.rsp_ready,
               inst_if.rsp_valid, data_if.rsp_valid, orphan);
    end
    @(negedge clk);
    checks++;
    if (orphan !== 1'b1) begin
      failures++;
      $display("FAIL orphan_pulse got=%b required=1", orphan);
    end
    @(negedge clk);
    checks++;
    if (orphan !== 1'b0) begin
      failures++;
      $display("FAIL orphan_single got=%b required=0", orphan);
    end
    rsp_en = 1'b0;
    for (int i = 0; i < 4; i++) inst_q.push_back(rd(32'h80 + 32'(4 * i)));
    repeat (3) tick();
    checks++;
    if (cnt !== 4'd3) begin
      failures++;
      $display("FAIL midburst_count got=%0d required=3", cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cnt !== 4'd0) begin
      failures++;
      $display("FAIL midburst_reset got=%0d required=0", cnt);
    end
    apply_reset();
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 32'hC0DE_0000 | 32'(i);
      ref_mem[i] = 32'hC0DE_0000 | 32'(i);
    end
    inst_if.cmd_valid = 1'b0;
    data_if.cmd_valid = 1'b0;
    inst_if.rsp_ready = 1'b1;
    data_if.rsp_ready = 1'b1;
    {inst_if.cmd_addr, inst_if.cmd_read, inst_if.cmd_wdata, inst_if.cmd_wmask} = '0;
    {data_if.cmd_addr, data_if.cmd_read, data_if.cmd_wdata, data_if.cmd_wmask} = '0;
    {df_inst.cmd_addr, df_inst.cmd_read, df_inst.cmd_wdata, df_inst.cmd_wmask, df_inst.cmd_valid} = '0;
    {df_data.cmd_addr, df_data.cmd_read, df_data.cmd_wdata, df_data.cmd_wmask, df_data.cmd_valid} = '0;
    df_inst.rsp_ready = 1'b1;
    df_data.rsp_ready = 1'b1;
    df_mem.cmd_ready = 1'b0;
    df_mem.rsp_valid = 1'b0;
    df_mem.rsp_rdata = '0;
    df_mem.rsp_err = 1'b0;
    @(negedge clk);
    test_reset();
    test_fetch_only();
    test_round_robin();
    test_lock();
    test_full();
    test_store_load();
    test_orphan_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
